// File: rtl/aes_round_scheduler.sv
// Iterative AES encryption controller: round-robin arbiter for two requesters,
// working state register, round stepper and valid/ready result channel.
module aes_round_scheduler #(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              HCLK,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] res_data,
    output logic              rnd_en,
    output logic [3:0]        rnd_idx,
    output logic [DATA_W-1:0] rnd_in,
    input  logic [DATA_W-1:0] rnd_out,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LAST    = 4'(NUM_ROUNDS);

    logic [1:0]        fsm;
    logic              pri;
    logic              owner;
    logic [3:0]        round;
    logic [DATA_W-1:0] state_reg;
    logic [1:0]        grant;
    logic              grant_id;

    // Grant is combinational so the requester sees ready in the same cycle as valid.
    always_comb begin
        grant = 2'b00;
        if (fsm == ST_IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = pri ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id  = grant[1];
    assign req_ready = grant;

    always_ff @(posedge HCLK) begin
        if (rst) begin
            fsm       <= ST_IDLE;
            pri       <= 1'b0;
            owner     <= 1'b0;
            round     <= 4'd0;
            state_reg <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (|grant) begin
                        state_reg <= grant_id ? req_data1 : req_data0;
                        owner     <= grant_id;
                        round     <= 4'd0;
                        pri       <= ~grant_id;
                        fsm       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_reg <= rnd_out;
                    if (round == LAST) begin
                        fsm <= ST_DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // Index is forced to 0 outside RUN so the datapath sees a quiet, known value.
    assign rnd_en    = (fsm == ST_RUN);
    assign rnd_idx   = rnd_en ? round : 4'd0;
    assign rnd_in    = state_reg;
    assign res_valid = (fsm == ST_DONE);
    assign res_data  = state_reg;
    assign res_id    = owner;
    assign busy      = (fsm != ST_IDLE);
endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler with a behavioural AES-128 round datapath.
module tb_aes_round_scheduler;
    localparam int NR = 10;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         HCLK = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data0;
    logic [127:0] req_data1;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [127:0] res_data;
    logic         rnd_en;
    logic [3:0]   rnd_idx;
    logic [127:0] rnd_in;
    logic [127:0] rnd_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_scheduler #(.NUM_ROUNDS(NR), .DATA_W(128)) dut (
        .HCLK(HCLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data),
        .rnd_en(rnd_en), .rnd_idx(rnd_idx),
        .rnd_in(rnd_in), .rnd_out(rnd_out),
        .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from first principles: x^254 inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [3:0] idx);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] k;
        int           base;
        k  = KEY;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        base = (int'(idx) > NR) ? 0 : 4 * int'(idx);
        return {w[base], w[base+1], w[base+2], w[base+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [3:0] idx);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   s0, s1, s2, s3;
        logic [127:0] o;
        if (idx == 4'd0) return st ^ round_key(4'd0);
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
            if (idx != 4'(NR)) begin
                a[4*c]   = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
                a[4*c+1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
                a[4*c+2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
                a[4*c+3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
            end else begin
                a[4*c] = s0; a[4*c+1] = s1; a[4*c+2] = s2; a[4*c+3] = s3;
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        return o ^ round_key(idx);
    endfunction

    always_comb rnd_out = aes_round(rnd_in, rnd_idx);

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        req_data0 = PT; req_data1 = PT;
        tick; tick;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        req_valid = 2'b00; rst = 1'b0;
        #1;
        n_checks++;
        if ({res_valid, res_id, rnd_en, busy, rnd_idx} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got valid=%b id=%b en=%b busy=%b idx=%0d expected all 0",
                               res_valid, res_id, rnd_en, busy, rnd_idx);
        end
        n_checks++;
        if (res_data !== 128'h0 || rnd_in !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got res_data=%h rnd_in=%h expected 0", res_data, rnd_in);
        end
    endtask

    task automatic test_single;
        req_data0 = PT; req_data1 = 128'h0; res_ready = 1'b1; req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b expected 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        n_checks++;
        if (rnd_in !== PT) begin
            n_fail++; $display("FAIL single_rnd_in: got %h expected %h", rnd_in, PT);
        end
        for (int k = 0; k <= NR; k++) begin
            n_checks++;
            if (rnd_en !== 1'b1 || busy !== 1'b1 || rnd_idx !== 4'(k)) begin
                n_fail++; $display("FAIL single_idx: got en=%b busy=%b idx=%0d expected en=1 busy=1 idx=%0d",
                                   rnd_en, busy, rnd_idx, k);
            end
            tick;
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== CT || rnd_en !== 1'b0) begin
            n_fail++; $display("FAIL single_result: got valid=%b id=%b data=%h en=%b expected 1 0 %h 0",
                               res_valid, res_id, res_data, rnd_en, CT);
        end
        tick;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got valid=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_contention;
        do_reset;
        req_data0 = PT; req_data1 = PT; res_ready = 1'b1; req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL cont_first_grant: got %b expected 01", req_ready);
        end
        tick;
        repeat (NR + 1) begin
            n_checks++;
            if (req_ready !== 2'b00) begin
                n_fail++; $display("FAIL cont_blocked_run: got %b expected 00", req_ready);
            end
            tick;
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== CT || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL cont_result0: got valid=%b id=%b data=%h ready=%b expected 1 0 %h 00",
                               res_valid, res_id, res_data, req_ready, CT);
        end
        tick;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL cont_second_grant: got %b expected 10", req_ready);
        end
        tick;
        repeat (NR + 1) tick;
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== CT) begin
            n_fail++; $display("FAIL cont_result1: got valid=%b id=%b data=%h expected 1 1 %h",
                               res_valid, res_id, res_data, CT);
        end
        tick;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL cont_third_grant: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
        tick;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL cont_drop_no_commit: got busy=%b ready=%b expected 0 00", busy, req_ready);
        end
    endtask

    task automatic test_backpressure;
        req_data0 = ~PT; req_data1 = PT; res_ready = 1'b0; req_valid = 2'b10;
        tick;
        req_valid = 2'b00;
        repeat (NR + 1) tick;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== CT || rnd_en !== 1'b0 || rnd_idx !== 4'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b id=%b data=%h en=%b idx=%0d expected 1 1 %h 0 0",
                                   i, res_valid, res_id, res_data, rnd_en, rnd_idx, CT);
            end
            if (i == 5) res_ready = 1'b1;
            tick;
        end
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_blocking;
        req_data0 = PT; req_data1 = PT; res_ready = 1'b1; req_valid = 2'b01;
        tick;
        req_data0 = ~PT; req_valid = 2'b00;
        tick; tick;
        req_valid = 2'b10;
        repeat (NR) begin
            n_checks++;
            if (req_ready !== 2'b00) begin
                n_fail++; $display("FAIL block_ready: got %b expected 00", req_ready);
            end
            tick;
        end
        n_checks++;
        if (req_ready !== 2'b10 || busy !== 1'b0) begin
            n_fail++; $display("FAIL block_grant: got ready=%b busy=%b expected 10 0", req_ready, busy);
        end
        tick;
        req_valid = 2'b00;
        n_checks++;
        if (rnd_en !== 1'b1 || rnd_idx !== 4'd0) begin
            n_fail++; $display("FAIL block_start: got en=%b idx=%0d expected 1 0", rnd_en, rnd_idx);
        end
        repeat (NR + 1) tick;
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== CT) begin
            n_fail++; $display("FAIL block_result: got valid=%b id=%b data=%h expected 1 1 %h",
                               res_valid, res_id, res_data, CT);
        end
        tick;
    endtask

    task automatic test_reset_run;
        logic seen;
        req_data0 = PT; res_ready = 1'b1; req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        repeat (5) tick;
        n_checks++;
        if (rnd_idx !== 4'd5) begin
            n_fail++; $display("FAIL rstrun_idx5: got %0d expected 5", rnd_idx);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if ({res_valid, res_id, rnd_en, busy, rnd_idx} !== 8'h00 || res_data !== 128'h0 || rnd_in !== 128'h0) begin
            n_fail++; $display("FAIL rstrun_values: got valid=%b id=%b en=%b busy=%b idx=%0d data=%h expected all 0",
                               res_valid, res_id, rnd_en, busy, rnd_idx, res_data);
        end
        seen = 1'b0;
        repeat (15) begin
            if (res_valid === 1'b1) seen = 1'b1;
            tick;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rstrun_no_result: got res_valid seen=%b expected 0", seen);
        end
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        for (int k = 0; k <= NR; k++) begin
            n_checks++;
            if (rnd_en !== 1'b1 || rnd_idx !== 4'(k)) begin
                n_fail++; $display("FAIL rstrun_idx: got en=%b idx=%0d expected 1 %0d", rnd_en, rnd_idx, k);
            end
            tick;
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== CT) begin
            n_fail++; $display("FAIL rstrun_result: got valid=%b id=%b data=%h expected 1 0 %h",
                               res_valid, res_id, res_data, CT);
        end
        tick;
    endtask

    task automatic test_reset_done;
        req_data0 = PT; res_ready = 1'b0; req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        repeat (NR + 1) tick;
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstdone_pre: got res_valid=%b expected 1", res_valid);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || res_id !== 1'b0 || res_data !== 128'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstdone_values: got valid=%b id=%b data=%h busy=%b expected 0 0 0 0",
                               res_valid, res_id, res_data, busy);
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rstdone_pri: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
        req_data0 = 128'h0; req_data1 = 128'h0;
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_blocking;
        test_reset_run;
        test_reset_done;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Iterative-encryption controller and two-port arbiter for the shared AES round datapath. It accepts 128-bit plaintext blocks from two requesters under round-robin arbitration. It holds the working state register and steps the single-round datapath through round indices 0..NUM_ROUNDS, one per cycle. It then returns the ciphertext to the owning requester over a valid/ready response channel. It sits between the host-side request logic and the round datapath / subkey store. The round datapath selects its subkey from `rnd_idx`.

## Interface
- NUM_ROUNDS, 10, index of the final round; the block issues NUM_ROUNDS+1 round steps, idx 0 through NUM_ROUNDS (4-bit index, max 15)
- HCLK  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset, sampled on HCLK rising edge
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port accept; at most one bit high
- req_data0  in  128  port 0 plaintext
- req_data1  in  128  port 1 plaintext
- res_valid  out  1  ciphertext available
- res_ready  in  1  consumer accepts result
- res_id  out  1  owning port of res_data
- res_data  out  128  ciphertext
- rnd_en  out  1  round step active this cycle
- rnd_idx  out  4  round index: 0 = initial AddRoundKey, NUM_ROUNDS = final round with no MixColumns
- rnd_in  out  128  state presented to round datapath
- rnd_out  in  128  combinational round result for rnd_in/rnd_idx, valid in the same cycle
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - Grant logic: if only one port is valid, that port wins; if both are valid, the port named by priority pointer `pri` wins.
  - req_ready is high only for the winning port, combinationally from req_valid and pri. Both bits are 0 when no port is valid, when rst is high, or when not in IDLE.
  - Handshake occurs when req_valid[i] & req_ready[i]. On it: state_reg <= req_data_i, owner <= i, round <= 0, pri <= ~i, go to RUN.
- RUN
  - Outputs: rnd_en=1, rnd_in=state_reg, rnd_idx=round.
  - Each cycle: state_reg <= rnd_out.
  - If round==NUM_ROUNDS, go to DONE; otherwise round <= round+1.
  - Requests are ignored and req_ready stays 0.
- DONE
  - Outputs: res_valid=1, res_data=state_reg, res_id=owner. All three are held stable until the response handshake.
  - On res_valid & res_ready, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Arithmetic:
  - round is a 4-bit counter with no wrap; it never exceeds NUM_ROUNDS.
  - state_reg is captured as-is; no arithmetic on data.
- rnd_en=0 outside RUN. In that case rnd_idx=0 and rnd_in=state_reg, and the datapath ignores both.
- Reset values: FSM=IDLE, pri=0, owner=0, round=0, state_reg=0. Hence res_valid=0, res_id=0, res_data=0, rnd_en=0, rnd_idx=0, rnd_in=0, busy=0, req_ready=2'b00.
- Reset mid-operation, in RUN or DONE: the in-flight block is discarded and no res_valid is produced for it. The next accepted request starts at idx 0.
- A requester may drop req_valid before the grant; only a completed handshake commits.

## Timing
- Cycle 0: rising edge with request handshake.
- Cycles 1..NUM_ROUNDS+1: RUN, with rnd_idx = 0,1,…,NUM_ROUNDS on consecutive cycles.
- Cycle NUM_ROUNDS+2: res_valid first high. This is cycle 12 for the default NUM_ROUNDS.
- If res_ready is high in that cycle, the block is in IDLE at cycle 13 and the next handshake can be at cycle 13. Minimum initiation interval = NUM_ROUNDS+3 = 13 cycles.
- Backpressure: each cycle res_ready is low extends DONE by one cycle with outputs unchanged.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1,… starting with port 0 after reset.
- rst asserted on any edge takes priority over all other transitions in that edge.

## Test plan
- Single block, port 0:
  - Stimulus: round datapath modelled with the key 000102030405060708090a0b0c0d0e0f, req_data0=00112233445566778899aabbccddeeff.
  - Response: rnd_idx steps 0..10 on cycles 1..11; res_valid rises at cycle 12 with res_data=69c4e0d86a7b0430d8cdb78070b4c55a and res_id=0.
- Contention:
  - Stimulus: both ports valid from reset, port 1 data = same plaintext.
  - Response: port 0 is granted first; port 1 is granted at cycle 13 with res_id=1 and the same ciphertext. The next contention grants port 0 again.
- Backpressure:
  - Stimulus: res_ready held low for 5 cycles after res_valid rises.
  - Response: res_valid, res_data and res_id are stable for 6 cycles; the block returns to IDLE the cycle after res_ready=1.
- Blocking:
  - Stimulus: port 1 asserts valid during RUN.
  - Response: req_ready stays 2'b00 until IDLE, then the port 1 handshake happens.
- Reset mid-RUN:
  - Stimulus: rst asserted for one cycle when rnd_idx=5.
  - Response: all outputs return to reset values and no res_valid appears. A new request then runs idx 0..10 and produces correct ciphertext.
- Reset in DONE:
  - Stimulus: rst asserted while res_valid=1 and res_ready=0.
  - Response: res_valid drops to 0 the cycle after the reset edge; pri returns to 0.
